// File: rtl/multi_word_compare.sv
// Multi-word compare / subtract engine.
//
// Operands arrive one word pair per accepted cycle, least-significant word first. Each word is
// subtracted as a + ~b + carry, with the carry chain starting at 1. CMP produces flags only. SUB
// also emits one difference word per accepted pair. The flags are latched when the final word is
// accepted and hold until the next completion.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   start_i, op_i                 begin operation (IDLE only); 0 = CMP, 1 = SUB
//   abort_i                       cancel the operation in progress (RUN only)
//   word_valid_i, a_word_i,
//   b_word_i                      operand word pair handshake and data
//   word_ready_o                  high in RUN
//   result_valid_o, result_word_o difference word pulse (SUB only)
//   word_index_o                  index of the next word expected
//   busy_o, done_o                RUN/DONE indicator, completion pulse
//   flag_*_o                      latched Z/N/C/V of the last completed operation
module multi_word_compare #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_WORDS  = 2,
   localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  op_i,
   input  logic                  abort_i,
   input  logic                  word_valid_i,
   input  logic [DATA_WIDTH-1:0] a_word_i,
   input  logic [DATA_WIDTH-1:0] b_word_i,
   output logic                  word_ready_o,
   output logic                  result_valid_o,
   output logic [DATA_WIDTH-1:0] result_word_o,
   output logic [IDX_W-1:0]      word_index_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  flag_zero_o,
   output logic                  flag_negative_o,
   output logic                  flag_carry_o,
   output logic                  flag_overflow_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                state_q, state_d;
   logic                  accept;
   logic                  op_sub_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  carry_q;
   logic                  zero_acc_q;
   logic                  result_valid_q;
   logic [DATA_WIDTH-1:0] result_word_q;
   logic                  flag_z_q, flag_n_q, flag_c_q, flag_v_q;

   logic [DATA_WIDTH:0]   sum;
   logic [DATA_WIDTH-1:0] diff;
   logic                  carry_out;
   logic                  last_word;

   // Subtraction by adding the inverted subtrahend; the carry out means "no borrow".
   assign sum       = {1'b0, a_word_i} + {1'b0, ~b_word_i} + {{DATA_WIDTH{1'b0}}, carry_q};
   assign diff      = sum[DATA_WIDTH-1:0];
   assign carry_out = sum[DATA_WIDTH];
   assign last_word = (idx_q == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      word_ready_o = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) state_d = StRun;
         end
         StRun: begin
            word_ready_o = 1'b1;
            busy_o       = 1'b1;
            // Abort wins over a concurrent word so nothing is consumed on the way out.
            if (abort_i) begin
               state_d = StIdle;
            end else if (word_valid_i) begin
               accept = 1'b1;
               if (last_word) state_d = StDone;
            end
         end
         StDone: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_sub_q       <= 1'b0;
         idx_q          <= '0;
         carry_q        <= 1'b0;
         zero_acc_q     <= 1'b0;
         result_valid_q <= 1'b0;
         result_word_q  <= '0;
         flag_z_q       <= 1'b0;
         flag_n_q       <= 1'b0;
         flag_c_q       <= 1'b0;
         flag_v_q       <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         if (state_q == StIdle && start_i) begin
            op_sub_q   <= op_i;
            idx_q      <= '0;
            carry_q    <= 1'b1;
            zero_acc_q <= 1'b1;
         end
         if (state_q == StRun && abort_i) begin
            idx_q <= '0;
         end
         if (accept) begin
            carry_q    <= carry_out;
            zero_acc_q <= zero_acc_q & (diff == '0);
            if (op_sub_q) begin
               result_word_q  <= diff;
               result_valid_q <= 1'b1;
            end
            if (last_word) begin
               idx_q    <= '0;
               flag_z_q <= zero_acc_q & (diff == '0);
               flag_n_q <= diff[DATA_WIDTH-1];
               flag_c_q <= carry_out;
               flag_v_q <= (a_word_i[DATA_WIDTH-1] != b_word_i[DATA_WIDTH-1]) &&
                           (diff[DATA_WIDTH-1] != a_word_i[DATA_WIDTH-1]);
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
      end
   end

   assign result_valid_o  = result_valid_q;
   assign result_word_o   = result_word_q;
   assign word_index_o    = idx_q;
   assign flag_zero_o     = flag_z_q;
   assign flag_negative_o = flag_n_q;
   assign flag_carry_o    = flag_c_q;
   assign flag_overflow_o = flag_v_q;

endmodule
